fdiv_half_precision: RTL

FDIV_HALF_PRECISION -- requirements
Module: fdiv_half_precision

---
 rtl/fdiv_half_precision.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fdiv_half_precision.sv
// fdiv_half_precision: multi-cycle half-precision divider.
// The quotient comes from a 12-step restoring division, so a normal
// operation takes 13 edges and a special operation takes 1 edge.
//   in_Clk, in_Reset_n         clock and asynchronous active-low reset
//   in_Start                   request; sampled only in IDLE
//   in_Sign/Exponent/Mantissa  _1 is the dividend, _2 is the divisor
//   out_Sign/Exponent/Mantissa quotient; held until the next result
//   out_Busy                   high whenever the FSM is not IDLE
//   out_Done                   one-cycle pulse after the result is written
//   SC_*                       status flags; cleared when a request is accepted
module fdiv_half_precision (
  input  logic       in_Clk,
  input  logic       in_Reset_n,
  input  logic       in_Start,
  input  logic       in_Sign_1,
  input  logic [4:0] in_Exponent_1,
  input  logic [9:0] in_Mantissa_1,
  input  logic       in_Sign_2,
  input  logic [4:0] in_Exponent_2,
  input  logic [9:0] in_Mantissa_2,
  output logic       out_Sign,
  output logic [4:0] out_Exponent,
  output logic [9:0] out_Mantissa,
  output logic       out_Busy,
  output logic       out_Done,
  output logic       SC_Exponent_Overflow,
  output logic       SC_Exponent_Underflow,
  output logic       SC_Divide_By_Zero
);
  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [4:0]  e1_q, e1_d, e2_q, e2_d;
  logic        z1_q, z1_d, i1_q, i1_d, z2_q, z2_d, i2_q, i2_d;
  logic [11:0] rem_q, rem_d;
  logic [10:0] div_q, div_d;
  logic [11:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        osgn_q, osgn_d;
  logic [4:0]  oexp_q, oexp_d;
  logic [9:0]  oman_q, oman_d;
  logic        done_q, done_d, ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  logic              z1_in, i1_in, z2_in, i2_in, qbit;
  logic [11:0]       diff;
  logic signed [6:0] ex, en;

  assign z1_in = (in_Exponent_1 == 5'd0)  && (in_Mantissa_1 == 10'd0);
  assign i1_in = (in_Exponent_1 == 5'h1f) && (in_Mantissa_1 == 10'h3ff);
  assign z2_in = (in_Exponent_2 == 5'd0)  && (in_Mantissa_2 == 10'd0);
  assign i2_in = (in_Exponent_2 == 5'h1f) && (in_Mantissa_2 == 10'h3ff);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    z1_d    = z1_q;
    i1_d    = i1_q;
    z2_d    = z2_q;
    i2_d    = i2_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    osgn_d  = osgn_q;
    oexp_d  = oexp_q;
    oman_d  = oman_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    qbit    = 1'b0;
    diff    = 12'd0;
    ex      = 7'sd0;
    en      = 7'sd0;
    case (state_q)
      IDLE: begin
        if (in_Start) begin
          sign_d  = in_Sign_1 ^ in_Sign_2;
          e1_d    = in_Exponent_1;
          e2_d    = in_Exponent_2;
          z1_d    = z1_in;
          i1_d    = i1_in;
          z2_d    = z2_in;
          i2_d    = i2_in;
          rem_d   = {2'b01, in_Mantissa_1};
          div_d   = {1'b1, in_Mantissa_2};
          quo_d   = 12'd0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = (z1_in || i1_in || z2_in || i2_in) ? NORMALIZE : DIVIDE;
        end
      end
      DIVIDE: begin
        // rem < 2*div holds at every step, so 12 bits always fit
        if (rem_q >= {1'b0, div_q}) begin
          qbit = 1'b1;
          diff = rem_q - {1'b0, div_q};
        end else begin
          diff = rem_q;
        end
        rem_d = {diff[10:0], 1'b0};
        quo_d = {quo_q[10:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_d = NORMALIZE;
      end
      NORMALIZE: begin
        done_d  = 1'b1;
        osgn_d  = sign_q;
        state_d = IDLE;
        if (z2_q) begin
          dbz_d  = 1'b1;
          oexp_d = z1_q ? 5'd0 : 5'h1f;
          oman_d = z1_q ? 10'd0 : 10'h3ff;
        end else if (z1_q || (i2_q && !i1_q)) begin
          oexp_d = 5'd0;
          oman_d = 10'd0;
        end else if (i1_q) begin
          oexp_d = 5'h1f;
          oman_d = 10'h3ff;
        end else begin
          ex = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 7'sd15;
          en = quo_q[11] ? ex : ex - 7'sd1;
          oman_d = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
          oexp_d = en[4:0];
          if (en >= 7'sd31) begin
            ovf_d  = 1'b1;
            oexp_d = 5'h1f;
            oman_d = 10'h3ff;
          end else if (en <= 7'sd0) begin
            unf_d  = 1'b1;
            oexp_d = 5'd0;
            oman_d = 10'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      e1_q    <= 5'd0;
      e2_q    <= 5'd0;
      z1_q    <= 1'b0;
      i1_q    <= 1'b0;
      z2_q    <= 1'b0;
      i2_q    <= 1'b0;
      rem_q   <= 12'd0;
      div_q   <= 11'd0;
      quo_q   <= 12'd0;
      cnt_q   <= 4'd0;
      osgn_q  <= 1'b0;
      oexp_q  <= 5'd0;
      oman_q  <= 10'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      z1_q    <= z1_d;
      i1_q    <= i1_d;
      z2_q    <= z2_d;
      i2_q    <= i2_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      osgn_q  <= osgn_d;
      oexp_q  <= oexp_d;
      oman_q  <= oman_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign out_Sign              = osgn_q;
  assign out_Exponent          = oexp_q;
  assign out_Mantissa          = oman_q;
  assign out_Busy              = (state_q != IDLE);
  assign out_Done              = done_q;
  assign SC_Exponent_Overflow  = ovf_q;
  assign SC_Exponent_Underflow = unf_q;
  assign SC_Divide_By_Zero     = dbz_q;
endmodule
